// File: rtl/distance_display_pkg.sv
// Shared types and constants for the distance seven-segment display.
// Holds the converter state enum, digit count and active-low segment codes.
package distance_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } conv_state_e;

    localparam int NUM_DIGITS  = 4;
    localparam int BIN_W       = 10;
    localparam int BCD_W       = 4 * NUM_DIGITS;
    localparam int SHIFT_ITERS = BIN_W;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential double-dabble, 10-bit binary to 4-digit BCD.
// Latency: start at N -> SHIFT N+1..N+10, done (UPDATE) at N+11, idle again at N+12.
// Backpressure: start is ignored while busy; no queuing.
module bin2bcd_seq
    import distance_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    conv_state_e              state, state_nxt;
    logic [BCD_W+BIN_W-1:0]   work, work_nxt, work_adj;
    logic [3:0]               iter, iter_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            iter  <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        iter_nxt  = iter;
        work_adj  = work;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nxt  = {{BCD_W{1'b0}}, bin};
                    iter_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Correct each BCD nibble before the shift so it carries at 10
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (work[BIN_W + 4*k +: 4] >= 4'd5)
                        work_adj[BIN_W + 4*k +: 4] = work[BIN_W + 4*k +: 4] + 4'd3;
                end
                work_nxt = work_adj << 1;
                iter_nxt = iter + 4'd1;
                if (iter == 4'(SHIFT_ITERS - 1))
                    state_nxt = UPDATE;
            end
            UPDATE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == UPDATE);
    assign bcd  = work[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/distance_seg_display.sv
// Purpose: converts a 10-bit cm distance to BCD and scans it onto a 4-digit 7-seg display.
// Latency: value offered at N is displayed from N+12; scan outputs are registered (1 cycle).
// Backpressure: dist_valid is dropped while busy. Optional macro: LEADING_ZERO_BLANK_EN.
module distance_seg_display
    import distance_display_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 1_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   distance_cm,
    input  logic               dist_valid,
    output logic               busy,
    output logic               over_range,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int SLOT_CYCLES = CLK_HZ / DIGIT_HZ;
    localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [BCD_W-1:0]   disp_bcd;
    logic [CNT_W-1:0]   slot_cnt;
    logic [1:0]         digit_idx;
    logic [3:0]         cur_digit;
    logic               blank;
    logic [6:0]         seg_nxt;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (dist_valid),
        .bin   (distance_cm),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Display registers only move on a completed conversion; a reset mid-conversion leaves 0
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd   <= '0;
            over_range <= 1'b0;
        end else if (conv_done) begin
            disp_bcd   <= conv_bcd;
            over_range <= (conv_bcd[15:12] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == CNT_W'(SLOT_CYCLES - 1)) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            slot_cnt  <= slot_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        cur_digit = disp_bcd[{digit_idx, 2'b00} +: 4];
        blank     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_idx)
            2'd3:    blank = (disp_bcd[15:12] == 4'd0);
            2'd2:    blank = (disp_bcd[15:8]  == 8'd0);
            2'd1:    blank = (disp_bcd[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank     = 1'b0;
`endif
        seg_nxt   = blank ? SEG_BLANK : seg_decode(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_nxt;
        end
    end

endmodule
